wbm_mch: RTL and testbench
==========================

WBM_MCH -- requirements
Module: wbm_mch

Interface
REQ-001 Parameter CH_NUM, default 4, number of DMA channels served (legal 1..8).
REQ-002 Parameter VERSION, default 32'h0002_aa55, value of the global VERSION register.
REQ-003 Clock and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-004 wb_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 wb_rst_n_i  in  1  synchronous active-low reset.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave controls.
REQ-007 wbs_sel_i  in  4  byte lanes; wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data.
REQ-008 wbs_dat_o  out  32  registered read data; wbs_ack_o, wbs_err_o, wbs_rty_o  out  1 each  registered terminations.
REQ-009 dar_i  in  CH_NUM*32; csr_i  in  CH_NUM*8; busy_i, done_i, err_i, ndar_dirty_clear_i, append_clear_i  in  CH_NUM each  per-channel DMA status; done_i/err_i are 1-cycle event pulses.
REQ-010 ndar_o  out  CH_NUM*29 (bits [31:3] per channel); ndar_dirty_o, enable_o, append_o, int_clear_o  out  CH_NUM each; int_o  out  1  aggregated interrupt.

Function
REQ-011 Address decode on wbs_adr_i[8:2]; channel c window at byte 0x20*c, c < CH_NUM: +0x00 CCR, +0x04 CSR, +0x08 DAR (RO), +0x0C NDAR, +0x10 INT_STAT, +0x14 INT_MASK; global 0x100 INT_SUMMARY (RO), 0x104 VERSION (RO); wbs_adr_i[31:9] ignored.
REQ-012 Request = cyc & stb & !ack & !err & !rty; exactly one of ack/err/rty SHALL assert for one cycle on the edge after request; none while stb low; back-to-back requests give termination every second cycle.
REQ-013 err on: unmapped address, channel index >= CH_NUM, sel==0, write to RO register, DAR/NDAR/VERSION access with sel != 4'b1111.
REQ-014 rty on NDAR write while that channel's enable_o=1; no state change.
REQ-015 Write side effects and wbs_dat_o capture occur on the same edge that asserts ack; err/rty cycles change no state; wbs_dat_o = 0 on non-ack cycles.
REQ-016 CCR write (requires sel[0]): append <- dat[0], enable <- dat[1], int_clear_o pulses 1 cycle if dat[2]; CCR read = {29'b0, 1'b0, enable, append}.
REQ-017 append_o cleared by append_clear_i; CCR write same cycle wins.
REQ-018 NDAR write: ndar_o <- dat[31:3], ndar_dirty_o <- 1; ndar_dirty_clear_i clears dirty; write same cycle wins; NDAR read = {ndar_o, 3'b000}; ndar_o not reset.
REQ-019 CSR read = {done_cnt[7:0], 8'b0, csr_i[c], 6'b0, busy_i[c], |(INT_STAT&INT_MASK)}; any CSR write (any nonzero sel) clears done_cnt.
REQ-020 done_cnt: +1 per done_i pulse, saturates at 255; clear and done_i same cycle -> 1.
REQ-021 INT_STAT[1:0] = {err, done} sticky, set by err_i/done_i; write-1-to-clear on bits [1:0]; int_clear_o pulse clears both; set beats clear same cycle.
REQ-022 INT_MASK[1:0] RW, bits [31:2] read 0.
REQ-023 int_o registered: next = OR over channels of |(INT_STAT & INT_MASK); one cycle after the causing state change.
REQ-024 INT_SUMMARY bit c = channel c pending-and-masked, bits >= CH_NUM read 0.

Reset
REQ-025 With wb_rst_n_i=0 at an edge: ack/err/rty, wbs_dat_o, enable_o, append_o, ndar_dirty_o, int_clear_o, int_o, INT_STAT, INT_MASK, done_cnt all 0.
REQ-026 Reset mid-transfer aborts it: no termination issued for a request pending at reset; master must re-issue.
REQ-027 Inputs done_i/err_i during reset are ignored.

Verification
REQ-028 Read 0x104 sel=1111 -> one-cycle ack, dat=32'h0002_aa55; read 0x0A0 with CH_NUM=4 -> one-cycle err, dat=0.
REQ-029 Ch1: CCR write 0x2 then NDAR write 0x1234_5678 -> rty, ndar_o[1] unchanged; CCR write 0x0, NDAR write -> ack, ndar_o[1]=0x1234_5678>>3, dirty=1; ndar_dirty_clear_i[1] -> dirty 0.
REQ-030 Ch0: INT_MASK=0x1, done_i pulse -> INT_STAT=0x1, int_o=1 next cycle; W1C 0x1 coincident with new done_i -> INT_STAT stays 0x1.
REQ-031 Ch2: 300 done_i pulses -> CSR[31:24]=0xFF; CSR write coincident with done_i -> 0x01.
REQ-032 Hold stb high 4 cycles on a read -> ack pattern 0,1,0,1; NDAR write with sel=0011 -> err, no change.
REQ-033 Assert reset while request pending -> no termination, all REQ-025 outputs 0 next cycle.

Source files
------------

// File: rtl/wbm_mch_if.sv
// Wishbone classic slave bus bundle for the multi-channel DMA register block.
// Signal names keep the slave-side _i/_o direction suffixes of the register block.
interface wbm_mch_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        wbs_rty_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );
endinterface

// File: rtl/wbm_mch.sv
// Per-channel DMA control/status registers behind a Wishbone classic slave.
// One-cycle registered ack/err/rty; a held strobe is terminated every second cycle.
module wbm_mch #(
  parameter int          CH_NUM  = 4,
  parameter logic [31:0] VERSION = 32'h0002_aa55
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  wbm_mch_if.slave               wb,
  input  logic [CH_NUM*32-1:0]   dar_i,
  input  logic [CH_NUM*8-1:0]    csr_i,
  input  logic [CH_NUM-1:0]      busy_i,
  input  logic [CH_NUM-1:0]      done_i,
  input  logic [CH_NUM-1:0]      err_i,
  input  logic [CH_NUM-1:0]      ndar_dirty_clear_i,
  input  logic [CH_NUM-1:0]      append_clear_i,
  output logic [CH_NUM*29-1:0]   ndar_o,
  output logic [CH_NUM-1:0]      ndar_dirty_o,
  output logic [CH_NUM-1:0]      enable_o,
  output logic [CH_NUM-1:0]      append_o,
  output logic [CH_NUM-1:0]      int_clear_o,
  output logic                   int_o
);
  localparam logic [2:0] OFF_CCR  = 3'd0;
  localparam logic [2:0] OFF_CSR  = 3'd1;
  localparam logic [2:0] OFF_DAR  = 3'd2;
  localparam logic [2:0] OFF_NDAR = 3'd3;
  localparam logic [2:0] OFF_STAT = 3'd4;
  localparam logic [2:0] OFF_MASK = 3'd5;

  logic                    ack_q, ack_d, err_q, err_d, rty_q, rty_d;
  logic [31:0]             dat_q, dat_d;
  logic [CH_NUM-1:0]       enable_q, enable_d, append_q, append_d;
  logic [CH_NUM-1:0]       dirty_q, dirty_d, int_clear_q, int_clear_d;
  logic [CH_NUM-1:0][1:0]  stat_q, stat_d, mask_q, mask_d;
  logic [CH_NUM-1:0][7:0]  cnt_q, cnt_d;
  logic [CH_NUM-1:0][28:0] ndar_q, ndar_d;
  logic                    int_q, int_d;

  logic [CH_NUM-1:0] pend;
  logic              req, is_glb, map_ok, ro_reg, full_reg, ch_en;
  logic              err_hit, rty_hit, wr;
  logic [2:0]        ch, off;
  logic [31:0]       rd_dat;
  logic              unused_adr;

  assign req        = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q & ~err_q & ~rty_q;
  assign is_glb     = wb.wbs_adr_i[8];
  assign ch         = wb.wbs_adr_i[7:5];
  assign off        = wb.wbs_adr_i[4:2];
  assign unused_adr = ^{wb.wbs_adr_i[31:9], wb.wbs_adr_i[1:0]};

  always_comb begin
    pend = '0;
    for (int c = 0; c < CH_NUM; c++) pend[c] = |(stat_q[c] & mask_q[c]);
  end

  // Decode and read mux; a channel index with no matching channel stays unmapped.
  always_comb begin
    map_ok   = 1'b0;
    ro_reg   = 1'b0;
    full_reg = 1'b0;
    ch_en    = 1'b0;
    rd_dat   = 32'd0;
    if (is_glb) begin
      if (wb.wbs_adr_i[7:2] == 6'd0) begin
        map_ok = 1'b1;
        ro_reg = 1'b1;
        rd_dat = {{(32-CH_NUM){1'b0}}, pend};
      end else if (wb.wbs_adr_i[7:2] == 6'd1) begin
        map_ok   = 1'b1;
        ro_reg   = 1'b1;
        full_reg = 1'b1;
        rd_dat   = VERSION;
      end
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (ch == 3'(c)) begin
          map_ok   = (off <= OFF_MASK);
          ro_reg   = (off == OFF_DAR);
          full_reg = (off == OFF_DAR) || (off == OFF_NDAR);
          ch_en    = enable_q[c];
          case (off)
            OFF_CCR:  rd_dat = {30'd0, enable_q[c], append_q[c]};
            OFF_CSR:  rd_dat = {cnt_q[c], 8'd0, csr_i[c*8 +: 8], 6'd0, busy_i[c], pend[c]};
            OFF_DAR:  rd_dat = dar_i[c*32 +: 32];
            OFF_NDAR: rd_dat = {ndar_q[c], 3'b000};
            OFF_STAT: rd_dat = {30'd0, stat_q[c]};
            OFF_MASK: rd_dat = {30'd0, mask_q[c]};
            default:  rd_dat = 32'd0;
          endcase
        end
      end
    end
  end

  assign err_hit = !map_ok || (wb.wbs_sel_i == 4'b0000) || (wb.wbs_we_i && ro_reg) ||
                   (full_reg && (wb.wbs_sel_i != 4'b1111));
  assign rty_hit = !err_hit && wb.wbs_we_i && !is_glb && (off == OFF_NDAR) && ch_en;
  assign wr      = req && wb.wbs_we_i && !err_hit && !rty_hit;

  always_comb begin
    ack_d       = req && !err_hit && !rty_hit;
    err_d       = req && err_hit;
    rty_d       = req && rty_hit;
    dat_d       = (ack_d && !wb.wbs_we_i) ? rd_dat : 32'd0;
    enable_d    = enable_q;
    append_d    = append_q;
    dirty_d     = dirty_q;
    int_clear_d = '0;
    stat_d      = stat_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    ndar_d      = ndar_q;
    int_d       = |pend;
    for (int c = 0; c < CH_NUM; c++) begin
      if (append_clear_i[c])     append_d[c] = 1'b0;
      if (ndar_dirty_clear_i[c]) dirty_d[c]  = 1'b0;
      if (done_i[c] && cnt_q[c] != 8'hFF) cnt_d[c] = cnt_q[c] + 8'd1;
      if (wr && !is_glb && ch == 3'(c)) begin
        case (off)
          OFF_CCR: if (wb.wbs_sel_i[0]) begin
            append_d[c]    = wb.wbs_dat_i[0];
            enable_d[c]    = wb.wbs_dat_i[1];
            int_clear_d[c] = wb.wbs_dat_i[2];
            if (wb.wbs_dat_i[2]) stat_d[c] = 2'b00;
          end
          OFF_CSR:  cnt_d[c] = {7'd0, done_i[c]};
          OFF_NDAR: begin
            ndar_d[c]  = wb.wbs_dat_i[31:3];
            dirty_d[c] = 1'b1;
          end
          OFF_STAT: if (wb.wbs_sel_i[0]) stat_d[c] = stat_q[c] & ~wb.wbs_dat_i[1:0];
          OFF_MASK: if (wb.wbs_sel_i[0]) mask_d[c] = wb.wbs_dat_i[1:0];
          default: ;
        endcase
      end
      // New events are applied last so they win over any clear in the same cycle.
      stat_d[c] = stat_d[c] | {err_i[c], done_i[c]};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rty_q       <= 1'b0;
      dat_q       <= 32'd0;
      enable_q    <= '0;
      append_q    <= '0;
      dirty_q     <= '0;
      int_clear_q <= '0;
      stat_q      <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      int_q       <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      err_q       <= err_d;
      rty_q       <= rty_d;
      dat_q       <= dat_d;
      enable_q    <= enable_d;
      append_q    <= append_d;
      dirty_q     <= dirty_d;
      int_clear_q <= int_clear_d;
      stat_q      <= stat_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      int_q       <= int_d;
      ndar_q      <= ndar_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_err_o = err_q;
  assign wb.wbs_rty_o = rty_q;
  assign wb.wbs_dat_o = dat_q;
  assign ndar_o       = ndar_q;
  assign ndar_dirty_o = dirty_q;
  assign enable_o     = enable_q;
  assign append_o     = append_q;
  assign int_clear_o  = int_clear_q;
  assign int_o        = int_q;
endmodule

// File: tb/tb_wbm_mch.sv
// Directed bench for wbm_mch: bus expectations are queued at issue time and
// checked by an independent termination monitor; sideband outputs checked inline.
module tb_wbm_mch;
  localparam int CH = 4;
  localparam logic [2:0] T_ACK = 3'b100;
  localparam logic [2:0] T_ERR = 3'b010;
  localparam logic [2:0] T_RTY = 3'b001;

  logic clk = 1'b0;
  logic rst_n;
  logic [CH*32-1:0] dar_i;
  logic [CH*8-1:0]  csr_i;
  logic [CH-1:0]    busy_i, done_i, err_i, ndar_dirty_clear_i, append_clear_i;
  logic [CH*29-1:0] ndar_o;
  logic [CH-1:0]    ndar_dirty_o, enable_o, append_o, int_clear_o;
  logic             int_o;

  int checks   = 0;
  int failures = 0;
  logic [34:0] exp_q[$];
  string       nm_q[$];

  wbm_mch_if bus();

  wbm_mch #(.CH_NUM(CH), .VERSION(32'h0002_aa55)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb(bus.slave),
    .dar_i(dar_i), .csr_i(csr_i), .busy_i(busy_i), .done_i(done_i), .err_i(err_i),
    .ndar_dirty_clear_i(ndar_dirty_clear_i), .append_clear_i(append_clear_i),
    .ndar_o(ndar_o), .ndar_dirty_o(ndar_dirty_o), .enable_o(enable_o),
    .append_o(append_o), .int_clear_o(int_clear_o), .int_o(int_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every termination must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [34:0] e;
    string n;
    if (bus.wbs_ack_o || bus.wbs_err_o || bus.wbs_rty_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_term: got term=%b dat=%h expected none",
                 {bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_rty_o}, bus.wbs_dat_o);
      end else begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        if ({bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_rty_o, bus.wbs_dat_o} !== e) begin
          failures++;
          $display("FAIL %s: got term=%b dat=%h expected term=%b dat=%h", n,
                   {bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_rty_o}, bus.wbs_dat_o,
                   e[34:32], e[31:0]);
        end
      end
    end
  end

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input logic [2:0] term,
                      input logic [31:0] edat, input string nm,
                      input logic [CH-1:0] dpulse = '0);
    logic got;
    exp_q.push_back({term, edat});
    nm_q.push_back(nm);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_sel_i = sel;  bus.wbs_dat_i = dat;
    done_i = dpulse;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      done_i = '0;
      if (bus.wbs_ack_o || bus.wbs_err_o || bus.wbs_rty_o) got = 1'b1;
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no termination expected term=%b", nm, term);
      void'(exp_q.pop_back());
      void'(nm_q.pop_back());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_term"}, {29'd0, bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_rty_o}, 32'd0);
    chk({nm, "_dat"}, bus.wbs_dat_o, 32'd0);
    chk({nm, "_side"}, {16'd0, enable_o, append_o, ndar_dirty_o, int_clear_o}, 32'd0);
    chk({nm, "_int"}, {31'd0, int_o}, 32'd0);
  endtask

  initial begin
    logic [3:0] pat;
    rst_n = 1'b0;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;
    dar_i = '0; csr_i = '0; busy_i = '0; done_i = '0; err_i = '0;
    ndar_dirty_clear_i = '0; append_clear_i = '0;
    dar_i[63:32] = 32'hDEAD_BEEF;
    csr_i[7:0]   = 8'h5A;
    busy_i[0]    = 1'b1;
    idle(3);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    idle(1);

    // Global registers and error decode
    xfer(0, 32'h104, 4'hF, 0, T_ACK, 32'h0002_aa55, "rd_version");
    xfer(0, 32'h0A0, 4'hF, 0, T_ERR, 32'd0, "rd_bad_ch");
    xfer(0, 32'h100, 4'hF, 0, T_ACK, 32'd0, "rd_summary0");
    xfer(0, 32'h018, 4'hF, 0, T_ERR, 32'd0, "rd_unmapped");
    xfer(0, 32'h000, 4'h0, 0, T_ERR, 32'd0, "rd_sel0");
    xfer(1, 32'h008, 4'hF, 32'h1, T_ERR, 32'd0, "wr_dar_ro");
    xfer(1, 32'h104, 4'hF, 32'h1, T_ERR, 32'd0, "wr_version_ro");
    xfer(0, 32'h028, 4'hF, 0, T_ACK, 32'hDEAD_BEEF, "rd_dar1");
    xfer(0, 32'h028, 4'h1, 0, T_ERR, 32'd0, "rd_dar_partial");
    xfer(0, 32'hFFFF_FF04, 4'hF, 0, T_ACK, 32'h0002_aa55, "rd_version_hiadr");

    // Channel 1 NDAR, dirty flag and retry while enabled
    xfer(1, 32'h02C, 4'hF, 32'hAAAA_AAA8, T_ACK, 32'd0, "wr_ndar1_a");
    chk("ndar1_a", 32'(ndar_o[57:29]), 32'h1555_5555);
    chk("dirty1_set", 32'(ndar_dirty_o), 32'h2);
    @(negedge clk); ndar_dirty_clear_i[1] = 1'b1;
    @(negedge clk); ndar_dirty_clear_i[1] = 1'b0;
    chk("dirty1_clr", 32'(ndar_dirty_o), 32'h0);
    xfer(1, 32'h020, 4'hF, 32'h2, T_ACK, 32'd0, "wr_ccr1_en");
    chk("enable1", 32'(enable_o), 32'h2);
    xfer(0, 32'h020, 4'hF, 0, T_ACK, 32'h2, "rd_ccr1");
    xfer(1, 32'h02C, 4'hF, 32'h1234_5678, T_RTY, 32'd0, "wr_ndar1_rty");
    chk("ndar1_kept", 32'(ndar_o[57:29]), 32'h1555_5555);
    chk("dirty1_kept", 32'(ndar_dirty_o), 32'h0);
    xfer(1, 32'h020, 4'hF, 32'h0, T_ACK, 32'd0, "wr_ccr1_dis");
    xfer(1, 32'h02C, 4'hF, 32'h1234_5678, T_ACK, 32'd0, "wr_ndar1_b");
    chk("ndar1_b", 32'(ndar_o[57:29]), 32'h0246_8ACF);
    chk("dirty1_b", 32'(ndar_dirty_o), 32'h2);
    xfer(0, 32'h02C, 4'hF, 0, T_ACK, 32'h1234_5678, "rd_ndar1");
    xfer(1, 32'h02C, 4'h3, 32'hFFFF_FFF8, T_ERR, 32'd0, "wr_ndar1_sel3");
    chk("ndar1_sel3", 32'(ndar_o[57:29]), 32'h0246_8ACF);

    // Channel 0 interrupt path
    xfer(1, 32'h014, 4'h1, 32'h1, T_ACK, 32'd0, "wr_mask0");
    @(negedge clk); done_i[0] = 1'b1;
    @(negedge clk); done_i[0] = 1'b0;
    chk("int_o_lag", 32'(int_o), 32'h0);
    @(negedge clk);
    chk("int_o_set", 32'(int_o), 32'h1);
    xfer(0, 32'h010, 4'hF, 0, T_ACK, 32'h1, "rd_stat0");
    xfer(0, 32'h004, 4'hF, 0, T_ACK, 32'h0100_5A03, "rd_csr0");
    xfer(1, 32'h010, 4'h1, 32'h1, T_ACK, 32'd0, "w1c_stat0_race", 4'b0001);
    xfer(0, 32'h010, 4'hF, 0, T_ACK, 32'h1, "rd_stat0_kept");
    xfer(1, 32'h010, 4'h1, 32'h1, T_ACK, 32'd0, "w1c_stat0");
    xfer(0, 32'h010, 4'hF, 0, T_ACK, 32'h0, "rd_stat0_clr");
    chk("int_o_clr", 32'(int_o), 32'h0);

    // Channel 2 done counter saturation and clear race
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); done_i[2] = 1'b1;
      @(negedge clk); done_i[2] = 1'b0;
    end
    xfer(0, 32'h044, 4'hF, 0, T_ACK, 32'hFF00_0000, "rd_csr2_sat");
    xfer(1, 32'h044, 4'h1, 32'h0, T_ACK, 32'd0, "wr_csr2_race", 4'b0100);
    xfer(0, 32'h044, 4'hF, 0, T_ACK, 32'h0100_0000, "rd_csr2_one");
    xfer(1, 32'h054, 4'h1, 32'h1, T_ACK, 32'd0, "wr_mask2");
    idle(2);
    chk("int_o_ch2", 32'(int_o), 32'h1);
    xfer(0, 32'h100, 4'h1, 0, T_ACK, 32'h4, "rd_summary2");
    xfer(1, 32'h040, 4'h1, 32'h5, T_ACK, 32'd0, "wr_ccr2_clr");
    chk("int_clear2", 32'(int_clear_o), 32'h4);
    chk("append2", 32'(append_o), 32'h4);
    @(negedge clk);
    chk("int_clear2_end", 32'(int_clear_o), 32'h0);
    append_clear_i[2] = 1'b1;
    @(negedge clk); append_clear_i[2] = 1'b0;
    chk("append2_clr", 32'(append_o), 32'h0);
    xfer(0, 32'h050, 4'hF, 0, T_ACK, 32'h0, "rd_stat2_clr");
    chk("int_o_ch2_clr", 32'(int_o), 32'h0);

    // Held strobe: one termination every second cycle
    exp_q.push_back({T_ACK, 32'h0002_aa55}); nm_q.push_back("hold_a");
    exp_q.push_back({T_ACK, 32'h0002_aa55}); nm_q.push_back("hold_b");
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'h104; bus.wbs_sel_i = 4'hF;
    pat[3] = bus.wbs_ack_o;
    for (int i = 2; i >= 0; i--) begin
      @(negedge clk);
      pat[i] = bus.wbs_ack_o;
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    chk("hold_pattern", 32'(pat), 32'h5);

    // Reset while a request is pending
    xfer(1, 32'h000, 4'h1, 32'h2, T_ACK, 32'd0, "wr_ccr0_en");
    @(negedge clk); done_i[0] = 1'b1;
    @(negedge clk); done_i[0] = 1'b0;
    idle(1);
    chk("int_o_pre_rst", 32'(int_o), 32'h1);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'h104; bus.wbs_sel_i = 4'hF;
    rst_n = 1'b0;
    done_i[0] = 1'b1;
    err_i[0]  = 1'b1;
    @(negedge clk);
    chk_reset_outs("mid_rst");
    done_i[0] = 1'b0;
    err_i[0]  = 1'b0;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk_reset_outs("post_rst");
    xfer(0, 32'h004, 4'hF, 0, T_ACK, 32'h0000_5A02, "rd_csr0_rst");
    xfer(0, 32'h010, 4'hF, 0, T_ACK, 32'h0, "rd_stat0_rst");
    xfer(0, 32'h014, 4'hF, 0, T_ACK, 32'h0, "rd_mask0_rst");

    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
